// File: rtl/mem_bus_arbiter.sv
// Purpose: shares the single-ported MIO bus between IF fetches and MEM loads/stores, MEM first.
// Latency: grant on the edge after req, ack pulses the cycle after the MIO_ready edge (min 3 edges).
// Backpressure: requesters stall until their ack; MIO_ready inserts wait states, abort after TIMEOUT cycles.
module mem_bus_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_ack,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic [DATA_W-1:0] bus_rdata,
   input  logic              MIO_ready,
   output logic              stall_if,
   output logic              stall_mem,
   output logic              bus_timeout
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   // Abort threshold: the counter reads TIMEOUT-1 in the last allowed BUSY cycle.
   localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

   logic [1:0] state;
   logic       grantMem;   // 1: current transaction belongs to MEM, 0: to IF
   logic [7:0] waitCnt;
   logic       busyDone;   // MIO completed the transaction this cycle
   logic       busyAbort;  // no completion and the wait budget is exhausted
   logic       isRead;     // transaction returns data (fetch or load)

   // MIO_ready wins over the timeout when both happen in the same cycle.
   always_comb begin
      busyDone  = (state == BUSY) && MIO_ready;
      busyAbort = (state == BUSY) && !MIO_ready && (waitCnt == LAST_WAIT);
      isRead    = !grantMem || !bus_we;
   end

   // Stalls follow the request directly so the pipeline releases in the ack cycle.
   assign stall_if  = if_req  & ~if_ack;
   assign stall_mem = mem_req & ~mem_ack;

   // Grant, bus drive and wait counting; bus fields are only loaded in IDLE so they hold through BUSY.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         grantMem  <= 1'b0;
         waitCnt   <= '0;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (mem_req) begin
                  grantMem  <= 1'b1;
                  bus_addr  <= mem_addr;
                  bus_wdata <= mem_wdata;
                  bus_we    <= mem_we;
                  bus_req   <= 1'b1;
                  state     <= BUSY;
               end else if (if_req) begin
                  grantMem  <= 1'b0;
                  bus_addr  <= if_addr;
                  bus_we    <= 1'b0;
                  bus_req   <= 1'b1;
                  state     <= BUSY;
               end
            end
            BUSY: begin
               waitCnt <= waitCnt + 8'd1;
               if (busyDone || busyAbort) begin
                  bus_req <= 1'b0;
                  bus_we  <= 1'b0;
                  state   <= RESP;
               end
            end
            RESP: begin
               waitCnt <= '0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Read data capture per requester; an aborted read returns zero, stores leave data untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_rdata  <= '0;
         mem_rdata <= '0;
      end else if ((busyDone || busyAbort) && isRead) begin
         if (grantMem) begin
            mem_rdata <= busyDone ? bus_rdata : '0;
         end else begin
            if_rdata  <= busyDone ? bus_rdata : '0;
         end
      end
   end

   // One-cycle ack pulse out of RESP, and the sticky timeout flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_ack      <= 1'b0;
         mem_ack     <= 1'b0;
         bus_timeout <= 1'b0;
      end else begin
         if_ack  <= (state == RESP) && !grantMem;
         mem_ack <= (state == RESP) &&  grantMem;
         if (busyAbort) begin
            bus_timeout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: directed scenarios plus randomized transactions.
// Expectations come from a transaction-level model: who is granted, how many BUSY cycles, what data returns.
// The bench acts as the MIO slave and as both requesters.
module tb_mem_bus_arbiter;

   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 15;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              if_req = 1'b0;
   logic [ADDR_W-1:0] if_addr = '0;
   logic [DATA_W-1:0] if_rdata;
   logic              if_ack;
   logic              mem_req = 1'b0;
   logic              mem_we = 1'b0;
   logic [ADDR_W-1:0] mem_addr = '0;
   logic [DATA_W-1:0] mem_wdata = '0;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;
   logic              bus_req;
   logic              bus_we;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_wdata;
   logic [DATA_W-1:0] bus_rdata = '0;
   logic              MIO_ready = 1'b0;
   logic              stall_if;
   logic              stall_mem;
   logic              bus_timeout;

   mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata), .MIO_ready(MIO_ready),
      .stall_if(stall_if), .stall_mem(stall_mem), .bus_timeout(bus_timeout)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [DATA_W-1:0] expIfRdata = '0;
   logic [DATA_W-1:0] expMemRdata = '0;
   logic              expTimeout = 1'b0;

   task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Idle cycles with no request: random MIO_ready noise must not start or finish anything.
   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         MIO_ready = 1'($urandom_range(0, 1));
         bus_rdata = $urandom;
         step();
         checkEq("idle_bus_req", bus_req, 1'b0);
         checkEq("idle_if_ack", if_ack, 1'b0);
         checkEq("idle_mem_ack", mem_ack, 1'b0);
      end
      MIO_ready = 1'b0;
   endtask

   // One transaction, starting right after the requester fields were driven.
   // k = BUSY cycle (1-based) in which MIO_ready is raised; k > TIMEOUT means never.
   task automatic doTxn(input bit isMem, input int k, input logic [DATA_W-1:0] rd,
                        input bit keepReq, input bit dropMid, output int ackCyc);
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] wd;
      logic              we;
      bit                to;
      int                nb;
      a  = isMem ? mem_addr : if_addr;
      we = isMem ? mem_we : 1'b0;
      wd = mem_wdata;
      to = (k > TIMEOUT);
      nb = to ? TIMEOUT : k;
      for (int c = 1; c <= nb; c++) begin
         step();
         checkEq("busy_req", bus_req, 1'b1);
         checkEq("busy_addr", bus_addr, a);
         checkEq("busy_we", bus_we, we);
         if (we) checkEq("busy_wdata", bus_wdata, wd);
         checkEq("busy_if_ack", if_ack, 1'b0);
         checkEq("busy_mem_ack", mem_ack, 1'b0);
         checkEq("busy_stall_if", stall_if, if_req);
         checkEq("busy_stall_mem", stall_mem, mem_req);
         if (dropMid) begin
            if (isMem) mem_req = 1'b0;
            else       if_req  = 1'b0;
         end
         MIO_ready = (c == k);
         bus_rdata = (c == k) ? rd : $urandom;
      end
      step();
      checkEq("resp_req", bus_req, 1'b0);
      if (!to) checkEq("resp_we", bus_we, 1'b0);
      checkEq("resp_if_ack", if_ack, 1'b0);
      checkEq("resp_mem_ack", mem_ack, 1'b0);
      if (to) expTimeout = 1'b1;
      checkEq("resp_timeout", bus_timeout, expTimeout);
      MIO_ready = 1'($urandom_range(0, 1));
      bus_rdata = $urandom;
      step();
      if (!(isMem && we)) begin
         if (isMem) expMemRdata = to ? '0 : rd;
         else       expIfRdata  = to ? '0 : rd;
      end
      checkEq("ack_if", if_ack, !isMem);
      checkEq("ack_mem", mem_ack, isMem);
      checkEq("ack_bus_req", bus_req, 1'b0);
      checkEq("if_rdata", if_rdata, expIfRdata);
      checkEq("mem_rdata", mem_rdata, expMemRdata);
      checkEq("ack_timeout", bus_timeout, expTimeout);
      checkEq("ack_stall_if", stall_if, isMem ? if_req : 1'b0);
      checkEq("ack_stall_mem", stall_mem, isMem ? 1'b0 : mem_req);
      ackCyc = cyc;
      MIO_ready = 1'b0;
      if (!keepReq) begin
         if (isMem) mem_req = 1'b0;
         else       if_req  = 1'b0;
      end
   endtask

   initial begin
      int ackCyc;
      int prevAck;
      int mode;
      int k1;
      int k2;

      // Reset values are visible while rst_n is low, before any clock edge.
      #2;
      checkEq("rst_bus_req", bus_req, 1'b0);
      checkEq("rst_bus_we", bus_we, 1'b0);
      checkEq("rst_bus_addr", bus_addr, '0);
      checkEq("rst_bus_wdata", bus_wdata, '0);
      checkEq("rst_if_ack", if_ack, 1'b0);
      checkEq("rst_mem_ack", mem_ack, 1'b0);
      checkEq("rst_if_rdata", if_rdata, '0);
      checkEq("rst_mem_rdata", mem_rdata, '0);
      checkEq("rst_timeout", bus_timeout, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      idleCycles(2);

      // Single fetch, ready in the 2nd BUSY cycle.
      if_req = 1'b1; if_addr = 32'h0000_0004;
      doTxn(1'b0, 2, 32'h2008_0005, 1'b0, 1'b0, ackCyc);
      idleCycles(1);

      // Simultaneous requests: MEM load first, then IF.
      if_req = 1'b1; if_addr = 32'h0000_0040;
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h10;
      doTxn(1'b1, 1, 32'h1111_2222, 1'b0, 1'b0, ackCyc);
      doTxn(1'b0, 1, 32'h3333_4444, 1'b0, 1'b0, ackCyc);
      idleCycles(1);

      // Store with ready after 3 cycles; mem_rdata must not change.
      mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h20; mem_wdata = 32'hDEAD_BEEF;
      doTxn(1'b1, 3, 32'hCAFE_F00D, 1'b0, 1'b0, ackCyc);
      idleCycles(1);

      // Ready in the last allowed cycle wins over the abort.
      if_req = 1'b1; if_addr = 32'h0000_0100;
      doTxn(1'b0, TIMEOUT, 32'h5A5A_A5A5, 1'b0, 1'b0, ackCyc);
      idleCycles(1);

      // Timeout, then a normal fetch with the flag staying set.
      if_req = 1'b1; if_addr = 32'h0000_0200;
      doTxn(1'b0, TIMEOUT + 10, 32'h0, 1'b0, 1'b0, ackCyc);
      if_req = 1'b1; if_addr = 32'h0000_0204;
      doTxn(1'b0, 1, 32'h7777_8888, 1'b0, 1'b0, ackCyc);
      idleCycles(1);

      // Load whose request is withdrawn mid-transaction still completes.
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h30;
      doTxn(1'b1, 3, 32'h0BAD_CAFE, 1'b0, 1'b1, ackCyc);
      idleCycles(1);

      // Reset during BUSY clears outputs asynchronously.
      if_req = 1'b1; if_addr = 32'h0000_0300;
      step();
      step();
      checkEq("pre_rst_bus_req", bus_req, 1'b1);
      rst_n = 1'b0;
      #1;
      checkEq("mid_rst_bus_req", bus_req, 1'b0);
      checkEq("mid_rst_if_ack", if_ack, 1'b0);
      checkEq("mid_rst_timeout", bus_timeout, 1'b0);
      checkEq("mid_rst_mem_rdata", mem_rdata, '0);
      if_req = 1'b0;
      expIfRdata = '0; expMemRdata = '0; expTimeout = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      idleCycles(2);
      if_req = 1'b1; if_addr = 32'h0000_0304;
      doTxn(1'b0, 2, 32'h1234_5678, 1'b0, 1'b0, ackCyc);
      idleCycles(1);

      // Back-to-back fetches with req held across ack: one ack every 3 cycles.
      if_req = 1'b1; if_addr = 32'h0000_0400;
      prevAck = 0;
      for (int i = 0; i < 4; i++) begin
         doTxn(1'b0, 1, $urandom, (i < 3), 1'b0, ackCyc);
         if (i > 0) checkEq("b2b_ack_spacing", 64'(ackCyc - prevAck), 64'd3);
         prevAck = ackCyc;
      end
      idleCycles(1);

      // Randomized traffic.
      for (int n = 0; n < 60; n++) begin
         mode = $urandom_range(0, 2);
         k1 = ($urandom_range(0, 9) == 0) ? TIMEOUT + 3 : $urandom_range(1, 4);
         k2 = ($urandom_range(0, 9) == 0) ? TIMEOUT + 3 : $urandom_range(1, 4);
         if (mode != 1) begin
            if_req = 1'b1; if_addr = $urandom;
         end
         if (mode != 0) begin
            mem_req = 1'b1; mem_we = 1'($urandom_range(0, 1));
            mem_addr = $urandom; mem_wdata = $urandom;
         end
         if (mode != 0) doTxn(1'b1, k1, $urandom, 1'b0, 1'b0, ackCyc);
         if (mode != 1) doTxn(1'b0, k2, $urandom, 1'b0, 1'b0, ackCyc);
         idleCycles($urandom_range(0, 2));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
